// File: rtl/addsub_serial_if.sv
// rtl/addsub_serial_if.sv - operand/result handshake bundle for the digit-serial adder-subtractor
// master = operand source and result sink, slave = addsub_serial.
interface addsub_serial_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic             sel;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, sel, a, b, out_ready,
      input  in_ready, out_valid, s, cout, ovf
   );

   modport slave (
      input  in_valid, sel, a, b, out_ready,
      output in_ready, out_valid, s, cout, ovf
   );
endinterface

// File: rtl/addsub_serial.sv
// rtl/addsub_serial.sv - digit-serial add/sub, CHUNK bits per clock with a registered carry
// Optional ADDSUB_SATURATE_EN: clamp s to max-positive/min-negative on signed overflow.
module addsub_serial #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   addsub_serial_if.slave  bus
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

   state_t           state;
   state_t           state_nxt;
   logic             accept;
   logic             calc;
   logic             last;
   logic [KW-1:0]    k;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] s_reg;
   logic [WIDTH-1:0] s_nxt;
   logic             carry_reg;
   logic             c_msb;
   logic             c_msb_nxt;
   logic [CHUNK:0]   sum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      calc      = 1'b0;
      case (state)
         IDLE: if (bus.in_valid) begin
            accept    = 1'b1;
            state_nxt = CALC;
         end
         CALC: begin
            calc = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign last = (k == KW'(NCHUNK - 1));

   // Operands shift right so the active chunk is always in the low CHUNK bits;
   // result chunks enter at the top and reach their final position after NCHUNK steps.
   always_comb begin
      sum       = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_sh[CHUNK-1:0]} + (CHUNK+1)'(carry_reg);
      c_msb_nxt = sum[CHUNK-1] ^ a_sh[CHUNK-1] ^ b_sh[CHUNK-1];
      s_nxt     = (s_reg >> CHUNK) | (WIDTH'(sum[CHUNK-1:0]) << (WIDTH - CHUNK));
`ifdef ADDSUB_SATURATE_EN
      if (last && (c_msb_nxt ^ sum[CHUNK]))
         s_nxt = a_sh[CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh      <= '0;
         b_sh      <= '0;
         s_reg     <= '0;
         carry_reg <= 1'b0;
         c_msb     <= 1'b0;
         k         <= '0;
      end else if (accept) begin
         // Subtraction is A + ~B with the +1 entering as the initial carry.
         a_sh      <= bus.a;
         b_sh      <= bus.sel ? ~bus.b : bus.b;
         carry_reg <= bus.sel;
         k         <= '0;
      end else if (calc) begin
         a_sh      <= a_sh >> CHUNK;
         b_sh      <= b_sh >> CHUNK;
         s_reg     <= s_nxt;
         carry_reg <= sum[CHUNK];
         k         <= k + 1'b1;
         if (last) c_msb <= c_msb_nxt;
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.s         = s_reg;
   assign bus.cout      = carry_reg;
   assign bus.ovf       = c_msb ^ carry_reg;
endmodule

// File: tb/tb_addsub_serial.sv
// tb/tb_addsub_serial.sv - scoreboard bench for addsub_serial (WIDTH=16, CHUNK=4)
// Expected results are pushed on accept and checked by an independent result monitor.
module tb_addsub_serial;
   localparam int WIDTH  = 16;
   localparam int CHUNK  = 4;
   localparam int NCHUNK = WIDTH / CHUNK;
`ifdef ADDSUB_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   typedef struct packed {
      logic [WIDTH-1:0] s;
      logic             cout;
      logic             ovf;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   exp_t sb[$];
   exp_t mon_e;
   int   n_vec = 0;
   int   n_err = 0;
   int   lat;

   always #5 clk = ~clk;

   addsub_serial_if #(.WIDTH(WIDTH)) bus ();

   addsub_serial #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [WIDTH-1:0] s_wrap, input logic [WIDTH-1:0] s_sat,
                               input logic c, input logic o);
      exp_t e;
      e.s    = SAT ? s_sat : s_wrap;
      e.cout = c;
      e.ovf  = o;
      return e;
   endfunction

   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_result", 32'd1, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("s", 32'(bus.s), 32'(mon_e.s));
            chk("cout", 32'(bus.cout), 32'(mon_e.cout));
            chk("ovf", 32'(bus.ovf), 32'(mon_e.ovf));
         end
      end
   end

   // Returns #1 after the edge on which out_valid is first seen; lat = edges after accept.
   task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sel,
                       input exp_t e, output int latency);
      int w;
      latency = 0;
      @(negedge clk);
      bus.a = a; bus.b = b; bus.sel = sel; bus.in_valid = 1'b1;
      w = 0;
      while (!bus.in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!bus.in_ready) begin
         chk("accept_timeout", 32'd0, 32'd1);
         bus.in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      sb.push_back(e);
      #1 bus.in_valid = 1'b0;
      while (!bus.out_valid && latency < 50) begin
         @(posedge clk);
         #1 latency++;
      end
      if (!bus.out_valid) chk("done_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int w;
      bus.in_valid  = 1'b0;
      bus.sel       = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b1;

      #2 rst_n = 1'b0;
      #10;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_s", 32'(bus.s), 32'd0);
      chk("rst_cout", 32'(bus.cout), 32'd0);
      chk("rst_ovf", 32'(bus.ovf), 32'd0);
      @(negedge clk) rst_n = 1'b1;

      send(16'h1234, 16'h0F0F, 1'b0, mk(16'h2143, 16'h2143, 1'b0, 1'b0), lat);
      chk("latency_cycle", 32'(lat + 1), 32'(NCHUNK + 1));
      send(16'h7FFF, 16'h0001, 1'b0, mk(16'h8000, 16'h7FFF, 1'b0, 1'b1), lat);
      send(16'h0000, 16'h8000, 1'b1, mk(16'h8000, 16'h7FFF, 1'b0, 1'b1), lat);
      send(16'h0005, 16'h0005, 1'b1, mk(16'h0000, 16'h0000, 1'b1, 1'b0), lat);

      // Backpressure: result held while inputs wiggle.
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      send(16'h00FF, 16'h0101, 1'b0, mk(16'h0200, 16'h0200, 1'b0, 1'b0), lat);
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = ~bus.in_valid;
         bus.a = 16'($urandom);
         bus.b = 16'($urandom);
         bus.sel = ~bus.sel;
         @(negedge clk);
         chk("bp_s", 32'(bus.s), 32'h0200);
         chk("bp_cout", 32'(bus.cout), 32'd0);
         chk("bp_ovf", 32'(bus.ovf), 32'd0);
         chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
         chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
         @(posedge clk);
         #1;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      send(16'h8000, 16'h0001, 1'b1, mk(16'h7FFF, 16'h8000, 1'b1, 1'b1), lat);

      // Reset during the second CALC cycle discards the operation.
      @(posedge clk);
      #1;
      @(negedge clk);
      bus.a = 16'h1111; bus.b = 16'h2222; bus.sel = 1'b0; bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(posedge clk);
      #1 chk("busy_before_reset", 32'(bus.in_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("midrst_s", 32'(bus.s), 32'd0);
      chk("midrst_cout", 32'(bus.cout), 32'd0);
      chk("midrst_ovf", 32'(bus.ovf), 32'd0);
      chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      send(16'hFFFF, 16'h0001, 1'b0, mk(16'h0000, 16'h0000, 1'b1, 1'b0), lat);

      w = 0;
      while (sb.size() != 0 && w < 20) begin
         @(negedge clk);
         #1 w++;
      end
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
